// File: rtl/aes_ctrl_fsm.sv
// AES HWPE job controller: latches a job from the register file, clears the
// datapath, programs source/sink streams, counts finished blocks and signals
// job completion with a one-cycle event.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i, config registers hold the last job
// CLEAR | one-cycle clear pulse to streamer and engine
// ISSUE | source/sink stream requests outstanding until acknowledged
// RUN   | streams running, counting blocks and waiting for sink finish
// DONE  | one-cycle completion event, then back to IDLE
module aes_ctrl_fsm #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   soft_clear_i,
  input  logic [ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
  input  logic [LEN_WIDTH-1:0]   n_blocks_i,
  output logic                   clear_o,
  output logic                   src_req_o,
  input  logic                   src_ack_i,
  output logic [ADDR_WIDTH-1:0]  src_addr_o,
  output logic                   dst_req_o,
  input  logic                   dst_ack_i,
  output logic [ADDR_WIDTH-1:0]  dst_addr_o,
  output logic [LEN_WIDTH+1:0]   len_words_o,
  input  logic                   blk_done_i,
  input  logic                   dst_done_i,
  output logic                   busy_o,
  output logic                   done_evt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   n_blocks_q;
  logic [LEN_WIDTH-1:0]   blk_cnt_q;
  logic                   src_ok_q;
  logic                   dst_ok_q;
  logic                   dst_fin_q;

  logic                   src_ok_n;
  logic                   dst_ok_n;
  logic                   dst_fin_n;
  logic [LEN_WIDTH-1:0]   blk_cnt_n;

  // A stream word is 32 bits, a block is four words.
  assign len_words_o = {n_blocks_q, 2'b00};

  // Next values of the sticky handshake flags and the saturating block counter;
  // using them directly lets an ack or pulse take effect in the cycle it arrives.
  always_comb begin
    src_ok_n  = src_ok_q | src_ack_i;
    dst_ok_n  = dst_ok_q | dst_ack_i;
    dst_fin_n = dst_fin_q | dst_done_i;
    blk_cnt_n = blk_cnt_q;
    if (blk_done_i && (blk_cnt_q != n_blocks_q)) begin
      blk_cnt_n = blk_cnt_q + 1'b1;
    end
  end

  // Job sequencer with registered outputs; soft_clear_i overrides every transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      n_blocks_q <= '0;
      blk_cnt_q  <= '0;
      src_ok_q   <= 1'b0;
      dst_ok_q   <= 1'b0;
      dst_fin_q  <= 1'b0;
      src_addr_o <= '0;
      dst_addr_o <= '0;
      clear_o    <= 1'b0;
      src_req_o  <= 1'b0;
      dst_req_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_evt_o <= 1'b0;
    end else begin
      clear_o    <= 1'b0;
      done_evt_o <= 1'b0;
      if (soft_clear_i) begin
        state_q   <= IDLE;
        clear_o   <= 1'b1;
        src_req_o <= 1'b0;
        dst_req_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              src_addr_o <= src_addr_i;
              dst_addr_o <= dst_addr_i;
              n_blocks_q <= n_blocks_i;
              busy_o     <= 1'b1;
              if (n_blocks_i == '0) begin
                // Empty job: nothing to stream, report completion straight away.
                state_q    <= DONE;
                done_evt_o <= 1'b1;
              end else begin
                state_q <= CLEAR;
                clear_o <= 1'b1;
              end
            end
          end
          CLEAR: begin
            state_q   <= ISSUE;
            blk_cnt_q <= '0;
            src_ok_q  <= 1'b0;
            dst_ok_q  <= 1'b0;
            dst_fin_q <= 1'b0;
            src_req_o <= 1'b1;
            dst_req_o <= 1'b1;
          end
          ISSUE: begin
            src_ok_q  <= src_ok_n;
            dst_ok_q  <= dst_ok_n;
            src_req_o <= ~src_ok_n;
            dst_req_o <= ~dst_ok_n;
            blk_cnt_q <= blk_cnt_n;
            dst_fin_q <= dst_fin_n;
            if (src_ok_n && dst_ok_n) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            blk_cnt_q <= blk_cnt_n;
            dst_fin_q <= dst_fin_n;
            if ((blk_cnt_n == n_blocks_q) && dst_fin_n) begin
              state_q    <= DONE;
              done_evt_o <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// Bench for aes_ctrl_fsm: directed jobs, expected completions queued by the
// stimulus and checked by an independent monitor on done_evt_o.
module tb_aes_ctrl_fsm;

  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          soft_clear_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0;
  logic [AW-1:0] dst_addr_i = '0;
  logic [LW-1:0] n_blocks_i = '0;
  logic          clear_o;
  logic          src_req_o;
  logic          src_ack_i = 1'b0;
  logic [AW-1:0] src_addr_o;
  logic          dst_req_o;
  logic          dst_ack_i = 1'b0;
  logic [AW-1:0] dst_addr_o;
  logic [LW+1:0] len_words_o;
  logic          blk_done_i = 1'b0;
  logic          dst_done_i = 1'b0;
  logic          busy_o;
  logic          done_evt_o;

  aes_ctrl_fsm #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .soft_clear_i (soft_clear_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .n_blocks_i   (n_blocks_i),
    .clear_o      (clear_o),
    .src_req_o    (src_req_o),
    .src_ack_i    (src_ack_i),
    .src_addr_o   (src_addr_o),
    .dst_req_o    (dst_req_o),
    .dst_ack_i    (dst_ack_i),
    .dst_addr_o   (dst_addr_o),
    .len_words_o  (len_words_o),
    .blk_done_i   (blk_done_i),
    .dst_done_i   (dst_done_i),
    .busy_o       (busy_o),
    .done_evt_o   (done_evt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW+1:0] len;
  } job_t;

  job_t exp_q[$];
  job_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   clear_cnt = 0;
  int   req_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW+1:0] l);
    job_t j;
    j.src = s;
    j.dst = d;
    j.len = l;
    exp_q.push_back(j);
  endtask

  // Completion monitor: every done_evt_o must match the oldest queued job.
  always @(negedge clk_i) begin
    if (rst_ni && done_evt_o) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_src_addr", 64'(src_addr_o), 64'(mon_e.src));
        chk("done_dst_addr", 64'(dst_addr_o), 64'(mon_e.dst));
        chk("done_len_words", 64'(len_words_o), 64'(mon_e.len));
        chk("done_busy", 64'(busy_o), 64'd1);
      end
    end
    if (clear_o) clear_cnt++;
    if (src_req_o || dst_req_o) req_cnt++;
  end

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
    src_addr_i = s;
    dst_addr_i = d;
    n_blocks_i = n;
    start_i    = 1'b1;
    cyc();
    start_i    = 1'b0;
  endtask

  task automatic pulse_blk(input int n);
    for (int i = 0; i < n; i++) begin
      blk_done_i = 1'b1;
      cyc();
      blk_done_i = 1'b0;
      cyc();
    end
  endtask

  initial begin
    int d0, c0, r0;
    // reset state
    rst_ni = 1'b0;
    repeat (2) cyc();
    chk("rst_clear", 64'(clear_o), 0);
    chk("rst_src_req", 64'(src_req_o), 0);
    chk("rst_dst_req", 64'(dst_req_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_evt_o), 0);
    chk("rst_src_addr", 64'(src_addr_o), 0);
    chk("rst_len", 64'(len_words_o), 0);
    rst_ni = 1'b1;
    cyc();

    // 1: single block, same-cycle acks
    push_exp(32'h1000_0000, 32'h2000_0000, 18'd4);
    start_job(32'h1000_0000, 32'h2000_0000, 16'd1);
    chk("t1_clear_c1", 64'(clear_o), 1);
    chk("t1_noreq_c1", 64'(src_req_o), 0);
    chk("t1_busy_c1", 64'(busy_o), 1);
    chk("t1_src_addr", 64'(src_addr_o), 64'h1000_0000);
    cyc();
    chk("t1_src_req_c2", 64'(src_req_o), 1);
    chk("t1_dst_req_c2", 64'(dst_req_o), 1);
    chk("t1_clear_c2", 64'(clear_o), 0);
    src_ack_i = 1'b1;
    dst_ack_i = 1'b1;
    cyc();
    src_ack_i = 1'b0;
    dst_ack_i = 1'b0;
    chk("t1_src_req_drop", 64'(src_req_o), 0);
    chk("t1_dst_req_drop", 64'(dst_req_o), 0);
    blk_done_i = 1'b1;
    cyc();
    blk_done_i = 1'b0;
    chk("t1_no_early_done", 64'(done_evt_o), 0);
    dst_done_i = 1'b1;
    cyc();
    dst_done_i = 1'b0;
    chk("t1_done", 64'(done_evt_o), 1);
    cyc();
    chk("t1_done_one_cycle", 64'(done_evt_o), 0);
    chk("t1_idle_busy", 64'(busy_o), 0);

    // 2: four blocks, src ack three cycles after dst ack, extra block pulse
    push_exp(32'hA000_0010, 32'hB000_0020, 18'd16);
    start_job(32'hA000_0010, 32'hB000_0020, 16'd4);
    chk("t2_len_words", 64'(len_words_o), 16);
    cyc();
    dst_ack_i = 1'b1;
    cyc();
    dst_ack_i = 1'b0;
    chk("t2_dst_req_drop", 64'(dst_req_o), 0);
    chk("t2_src_req_held", 64'(src_req_o), 1);
    cyc();
    chk("t2_src_req_held2", 64'(src_req_o), 1);
    cyc();
    src_ack_i = 1'b1;
    cyc();
    src_ack_i = 1'b0;
    chk("t2_src_req_drop", 64'(src_req_o), 0);
    pulse_blk(5);
    chk("t2_no_done_wo_dst", 64'(done_evt_o), 0);
    dst_done_i = 1'b1;
    cyc();
    dst_done_i = 1'b0;
    chk("t2_done", 64'(done_evt_o), 1);
    cyc();
    chk("t2_busy_low", 64'(busy_o), 0);
    chk("t2_done_low", 64'(done_evt_o), 0);

    // 3: zero-length job, no clear and no requests
    d0 = done_cnt;
    c0 = clear_cnt;
    r0 = req_cnt;
    push_exp(32'hC000_0000, 32'hD000_0000, 18'd0);
    start_job(32'hC000_0000, 32'hD000_0000, 16'd0);
    repeat (3) cyc();
    chk("t3_done_count", 64'(done_cnt - d0), 1);
    chk("t3_no_clear", 64'(clear_cnt - c0), 0);
    chk("t3_no_req", 64'(req_cnt - r0), 0);
    chk("t3_idle", 64'(busy_o), 0);

    // 4: start during RUN ignored
    push_exp(32'h3000_0000, 32'h4000_0000, 18'd8);
    start_job(32'h3000_0000, 32'h4000_0000, 16'd2);
    cyc();
    src_ack_i = 1'b1;
    dst_ack_i = 1'b1;
    cyc();
    src_ack_i = 1'b0;
    dst_ack_i = 1'b0;
    start_job(32'hDEAD_BEE0, 32'hFEED_0000, 16'd7);
    chk("t4_src_addr_kept", 64'(src_addr_o), 64'h3000_0000);
    chk("t4_len_kept", 64'(len_words_o), 8);
    chk("t4_no_clear", 64'(clear_o), 0);
    pulse_blk(1);
    blk_done_i = 1'b1;
    dst_done_i = 1'b1;
    cyc();
    blk_done_i = 1'b0;
    dst_done_i = 1'b0;
    chk("t4_done_same_cycle", 64'(done_evt_o), 1);
    repeat (2) cyc();

    // 5: soft clear mid-RUN, then a fresh job restarts the block count
    d0 = done_cnt;
    start_job(32'h5000_0000, 32'h6000_0000, 16'd4);
    cyc();
    src_ack_i = 1'b1;
    dst_ack_i = 1'b1;
    cyc();
    src_ack_i = 1'b0;
    dst_ack_i = 1'b0;
    pulse_blk(2);
    soft_clear_i = 1'b1;
    cyc();
    soft_clear_i = 1'b0;
    chk("t5_soft_clear_pulse", 64'(clear_o), 1);
    chk("t5_soft_clear_idle", 64'(busy_o), 0);
    cyc();
    chk("t5_clear_one_cycle", 64'(clear_o), 0);
    chk("t5_no_done", 64'(done_cnt - d0), 0);
    push_exp(32'h5000_0000, 32'h6000_0000, 18'd16);
    start_job(32'h5000_0000, 32'h6000_0000, 16'd4);
    cyc();
    src_ack_i = 1'b1;
    dst_ack_i = 1'b1;
    cyc();
    src_ack_i = 1'b0;
    dst_ack_i = 1'b0;
    pulse_blk(3);
    dst_done_i = 1'b1;
    cyc();
    dst_done_i = 1'b0;
    chk("t5_no_done_3_of_4", 64'(done_evt_o), 0);
    blk_done_i = 1'b1;
    cyc();
    blk_done_i = 1'b0;
    chk("t5_done_after_4", 64'(done_evt_o), 1);
    repeat (2) cyc();

    // 6: async reset during ISSUE
    start_job(32'h7000_0000, 32'h8000_0000, 16'd3);
    cyc();
    chk("t6_in_issue", 64'(src_req_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_src_req", 64'(src_req_o), 0);
    chk("t6_rst_dst_req", 64'(dst_req_o), 0);
    chk("t6_rst_busy", 64'(busy_o), 0);
    chk("t6_rst_src_addr", 64'(src_addr_o), 0);
    chk("t6_rst_len", 64'(len_words_o), 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("t6_idle_after", 64'(busy_o), 0);

    // soft clear in IDLE wins over a simultaneous start
    src_addr_i   = 32'h9000_0000;
    n_blocks_i   = 16'd1;
    start_i      = 1'b1;
    soft_clear_i = 1'b1;
    cyc();
    start_i      = 1'b0;
    soft_clear_i = 1'b0;
    chk("idle_soft_clear_pulse", 64'(clear_o), 1);
    chk("idle_soft_clear_busy", 64'(busy_o), 0);
    chk("idle_soft_clear_no_latch", 64'(src_addr_o), 0);
    repeat (3) cyc();
    chk("idle_soft_clear_stays", 64'(busy_o), 0);

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
